// File: rtl/alu_pipe.sv
// Pipelined 74181-style ALU: logic/arithmetic result computed at the input,
// then carried through LAT valid-tagged register stages with a global stall.
module alu_pipe #(
    parameter int unsigned N   = 32,
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         m,
    input  logic [3:0]   s,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);

    logic [N-1:0] x_c;
    logic [N-1:0] y_c;
    logic [N-1:0] lres_c;
    logic [N:0]   sum_c;
    logic [N-1:0] res_d;
    logic         cy_d;
    logic         ov_d;

    logic [N-1:0] res_q [LAT];
    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] cy_q;
    logic [LAT-1:0] ov_q;

    logic stall;
    logic sticky_q;
    logic sticky_d;

    always_comb begin
        lres_c = '0;
        case (s)
            4'd0:  lres_c = ~a;
            4'd1:  lres_c = ~(a & b);
            4'd2:  lres_c = ~a | b;
            4'd3:  lres_c = '1;
            4'd4:  lres_c = ~(a | b);
            4'd5:  lres_c = ~b;
            4'd6:  lres_c = ~(a ^ b);
            4'd7:  lres_c = a | ~b;
            4'd8:  lres_c = ~a & b;
            4'd9:  lres_c = a ^ b;
            4'd10: lres_c = b;
            4'd11: lres_c = a | b;
            4'd12: lres_c = '0;
            4'd13: lres_c = a & ~b;
            4'd14: lres_c = a & b;
            4'd15: lres_c = a;
            default: lres_c = '0;
        endcase
    end

    // Arithmetic operand pairs; the sum is formed N+1 bits wide so cout is exact.
    always_comb begin
        x_c = '0;
        y_c = '0;
        case (s)
            4'd0:  begin x_c = a;        y_c = '1;       end
            4'd1:  begin x_c = a & b;    y_c = '1;       end
            4'd2:  begin x_c = a & ~b;   y_c = '1;       end
            4'd3:  begin x_c = '1;       y_c = '0;       end
            4'd4:  begin x_c = a;        y_c = a | ~b;   end
            4'd5:  begin x_c = a & b;    y_c = a | ~b;   end
            4'd6:  begin x_c = a;        y_c = ~b;       end
            4'd7:  begin x_c = a | ~b;   y_c = '0;       end
            4'd8:  begin x_c = a;        y_c = a | b;    end
            4'd9:  begin x_c = a;        y_c = b;        end
            4'd10: begin x_c = a & ~b;   y_c = a | b;    end
            4'd11: begin x_c = a | b;    y_c = '0;       end
            4'd12: begin x_c = a;        y_c = a;        end
            4'd13: begin x_c = a & b;    y_c = a;        end
            4'd14: begin x_c = a & ~b;   y_c = a;        end
            4'd15: begin x_c = a;        y_c = '0;       end
            default: begin x_c = '0;     y_c = '0;       end
        endcase
        sum_c = {1'b0, x_c} + {1'b0, y_c} + {{N{1'b0}}, cin};
    end

    always_comb begin
        res_d = lres_c;
        cy_d  = 1'b0;
        ov_d  = 1'b0;
        if (m) begin
            res_d = sum_c[N-1:0];
            cy_d  = sum_c[N];
            ov_d  = (x_c[N-1] == y_c[N-1]) && (sum_c[N-1] != x_c[N-1]);
        end
    end

    assign stall    = vld_q[LAT-1] && !out_ready;
    assign in_ready = !stall;

    // A stall freezes every stage, so bubbles stay in place until the output drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            cy_q  <= '0;
            ov_q  <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                res_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                res_q[0] <= res_d;
                cy_q[0]  <= cy_d;
                ov_q[0]  <= ov_d;
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
                cy_q[i]  <= cy_q[i-1];
                ov_q[i]  <= ov_q[i-1];
            end
        end
    end

    assign out       = res_q[LAT-1];
    assign cout      = cy_q[LAT-1];
    assign overflow  = ov_q[LAT-1];
    assign out_valid = vld_q[LAT-1];

    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (out_valid && out_ready && overflow) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit/LAT=2 instance and an 8-bit/LAT=1 instance.
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        iv1, ir1, cin1, m1, cout1, ovf1, ov1, ordy1, stk1, clr1;
    logic [31:0] a1, b1, out1;
    logic [3:0]  s1;

    logic        iv2, ir2, cin2, m2, cout2, ovf2, ov2, ordy2, stk2, clr2;
    logic [7:0]  a2, b2, out2;
    logic [3:0]  s2;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.N(32), .LAT(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1), .m(m1), .s(s1),
        .out(out1), .cout(cout1), .overflow(ovf1), .out_valid(ov1),
        .out_ready(ordy1), .ovf_sticky(stk1), .clr_sticky(clr1)
    );

    alu_pipe #(.N(8), .LAT(1)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .cin(cin2), .m(m2), .s(s2),
        .out(out2), .cout(cout2), .overflow(ovf2), .out_valid(ov2),
        .out_ready(ordy2), .ovf_sticky(stk2), .clr_sticky(clr2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Single op on dut1 with an otherwise empty pipeline; checks latency and result.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic icin, input logic im, input logic [3:0] is,
                          input logic [31:0] eo, input logic ec, input logic eov);
        @(negedge clk);
        a1 = ia; b1 = ib; cin1 = icin; m1 = im; s1 = is; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0; a1 = '0; b1 = '0;
        check({tag, " early"}, ov1, 0);
        @(negedge clk);
        check({tag, " valid"}, ov1, 1);
        check({tag, " out"}, out1, eo);
        check({tag, " cout"}, cout1, ec);
        check({tag, " ovf"}, ovf1, eov);
    endtask

    logic [31:0] lexp [16];
    logic [31:0] prev_out;
    logic        prev_stall, stall;
    int          sent, got;

    initial begin
        lexp = '{32'h0F0F0F0F, 32'h0FFF0FFF, 32'hFF0FFF0F, 32'hFFFFFFFF,
                 32'h000F000F, 32'h00FF00FF, 32'hF00FF00F, 32'hF0FFF0FF,
                 32'h0F000F00, 32'h0FF00FF0, 32'hFF00FF00, 32'hFFF0FFF0,
                 32'h00000000, 32'h00F000F0, 32'hF000F000, 32'hF0F0F0F0};

        reset = 1'b1;
        iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; m1 = 0; s1 = '0; ordy1 = 1; clr1 = 0;
        iv2 = 0; a2 = '0; b2 = '0; cin2 = 0; m2 = 0; s2 = '0; ordy2 = 1; clr2 = 0;
        repeat (3) @(negedge clk);
        check("rst out_valid", ov1, 0);
        check("rst out", out1, 0);
        check("rst cout", cout1, 0);
        check("rst ovf", ovf1, 0);
        check("rst sticky", stk1, 0);
        check("rst out_valid2", ov2, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post-rst in_ready", ir1, 1);

        run_op("add ovf", 32'h7FFFFFFF, 32'h1, 0, 1, 4'd9, 32'h80000000, 0, 1);
        check("sticky before", stk1, 0);
        @(negedge clk);
        check("sticky set", stk1, 1);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        check("sticky clr", stk1, 0);

        run_op("sub small", 32'h5, 32'h7, 1, 1, 4'd6, 32'hFFFFFFFE, 0, 0);
        run_op("sub ovf", 32'h80000000, 32'h1, 1, 1, 4'd6, 32'h7FFFFFFF, 1, 1);
        run_op("ones+1", 32'h12345678, 32'h0, 1, 1, 4'd3, 32'h0, 1, 0);
        run_op("a-1", 32'h5, 32'h0, 0, 1, 4'd0, 32'h4, 1, 0);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("logic s=%0d", i), 32'hF0F0F0F0, 32'hFF00FF00, 1, 0,
                   4'(i), lexp[i], 0, 0);
        end

        // Stream of 8 adds with out_ready dropped for three cycles.
        sent = 0; got = 0; prev_stall = 0; prev_out = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            ordy1 = !(c >= 5 && c < 8);
            #1;
            stall = ov1 && !ordy1;
            check("stream in_ready", ir1, !stall);
            if (stall && prev_stall) begin
                check("stall hold out", out1, prev_out);
                check("stall hold valid", ov1, 1);
            end
            if (ov1 && ordy1) begin
                check($sformatf("stream res %0d", got), out1, 32'(got + 1 + 256));
                got++;
            end
            prev_stall = stall;
            prev_out   = out1;
            if (sent < 8) begin
                iv1 = 1'b1; m1 = 1; s1 = 4'd9; cin1 = 0;
                if (ir1) begin
                    a1 = 32'(sent + 1); b1 = 32'd256;
                    sent++;
                end else begin
                    a1 = 32'hDEADBEEF; b1 = 32'hDEADBEEF;
                end
            end else begin
                iv1 = 1'b0;
            end
        end
        iv1 = 1'b0; ordy1 = 1'b1;
        check("stream count", 32'(got), 8);
        @(negedge clk);
        check("stream drained", ov1, 0);

        // Reset with two overflowing ops in flight.
        @(negedge clk);
        a1 = 32'h7FFFFFFF; b1 = 32'h1; cin1 = 0; m1 = 1; s1 = 4'd9; iv1 = 1'b1;
        @(negedge clk);
        a1 = 32'h7FFFFFFE; b1 = 32'h3;
        @(negedge clk);
        iv1 = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid-rst out_valid", ov1, 0);
        check("mid-rst sticky", stk1, 0);
        check("mid-rst out", out1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after-rst no result", ov1, 0);
            if (i == 0) check("after-rst in_ready", ir1, 1);
        end
        check("after-rst sticky", stk1, 0);

        // 8-bit, single-stage instance.
        @(negedge clk);
        a2 = 8'h55; b2 = 8'h00; cin2 = 1; m2 = 1; s2 = 4'd3; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        check("n8 valid", ov2, 1);
        check("n8 out", out2, 8'h00);
        check("n8 cout", cout2, 1);
        check("n8 ovf", ovf2, 0);
        a2 = 8'h7F; b2 = 8'h01; cin2 = 0; s2 = 4'd9; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        check("n8 ovf out", out2, 8'h80);
        check("n8 ovf flag", ovf2, 1);
        check("n8 sticky before", stk2, 0);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("n8 set beats clr", stk2, 1);
        check("n8 empty", ov2, 0);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("n8 clr", stk2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
